// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The controller drives the request side, the adder drives status and result.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop produce
// a + b + cin LSB first over WIDTH clocks; results appear only when complete.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic [1:0]       fa;

   // Returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sum_d    = sum_q;
      cout_d   = cout_q;
      fa       = full_add(a_sh_q[0], b_sh_q[0], carry_q);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            sum_sh_d = {fa[0], sum_sh_q[WIDTH-1:1]};
            carry_d  = fa[1];
            cnt_d    = cnt_q + CW'(1);
            // Last bit: publish the assembled word so ports never show partial shifts.
            if (cnt_q == LAST) begin
               sum_d   = sum_sh_d;
               cout_d  = fa[1];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake and
// boundary cases, a 3-bit instance for the exhaustive arithmetic sweep.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) bus8();
   serial_adder_if #(.WIDTH(3)) bus3();

   serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   serial_adder #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] prev_sum;
   logic       prev_cout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Counts edges until done is seen (bounded); result is the edge count.
   task automatic wait_done8(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus8.done && lat < 40);
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] es, input logic ec);
      int lat;
      @(negedge clk);
      bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
      check({tag, "_hold"}, 32'(bus8.sum), 32'(prev_sum));
      wait_done8(lat);
      check({tag, "_lat"}, 32'(lat), 32'd8);
      check({tag, "_busy_done"}, 32'(bus8.busy), 32'd0);
      check({tag, "_sum"}, 32'(bus8.sum), 32'(es));
      check({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
      prev_sum  = es;
      prev_cout = ec;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int lat;
      int extra;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0;
      prev_sum = 8'h00; prev_cout = 1'b0;

      #1;
      check("rst_busy", 32'(bus8.busy), 32'd0);
      check("rst_done", 32'(bus8.done), 32'd0);
      check("rst_sum",  32'(bus8.sum),  32'd0);
      check("rst_cout", 32'(bus8.cout), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run8("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
      run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Start during RUN must be ignored.
      @(negedge clk);
      bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      wait_done8(lat);
      check("busy_ign_lat", 32'(lat), 32'd5);
      check("busy_ign_sum", 32'(bus8.sum), 32'h30);
      check("busy_ign_cout", 32'(bus8.cout), 32'd0);
      extra = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus8.done) extra++;
      end
      check("busy_ign_extra_done", 32'(extra), 32'd0);
      check("busy_ign_sum_held", 32'(bus8.sum), 32'h30);

      // Back-to-back with start held high.
      @(negedge clk);
      bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.a = 8'h80; bus8.b = 8'h80;
      wait_done8(lat);
      check("b2b_lat1", 32'(lat), 32'd8);
      check("b2b_sum1", 32'(bus8.sum), 32'h02);
      check("b2b_cout1", 32'(bus8.cout), 32'd0);
      wait_done8(lat);
      bus8.start = 1'b0;
      check("b2b_spacing", 32'(lat), 32'd9);
      check("b2b_sum2", 32'(bus8.sum), 32'h00);
      check("b2b_cout2", 32'(bus8.cout), 32'd1);
      @(posedge clk); #1;
      check("b2b_idle_busy", 32'(bus8.busy), 32'd0);
      check("b2b_idle_done", 32'(bus8.done), 32'd0);
      prev_sum = 8'h00; prev_cout = 1'b1;

      // Asynchronous reset mid-operation.
      @(negedge clk);
      bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(bus8.busy), 32'd0);
      check("arst_done", 32'(bus8.done), 32'd0);
      check("arst_sum",  32'(bus8.sum),  32'd0);
      check("arst_cout", 32'(bus8.cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus8.done) extra++;
      end
      check("arst_no_done", 32'(extra), 32'd0);
      prev_sum = 8'h00; prev_cout = 1'b0;
      run8("after_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

      // Exhaustive 3-bit sweep.
      for (int ia = 0; ia < 8; ia++) begin
         for (int ib = 0; ib < 8; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               int l3;
               @(negedge clk);
               bus3.a = 3'(ia); bus3.b = 3'(ib); bus3.cin = 1'(ic); bus3.start = 1'b1;
               @(posedge clk); #1;
               bus3.start = 1'b0;
               l3 = 0;
               do begin
                  @(posedge clk); #1;
                  l3++;
               end while (!bus3.done && l3 < 20);
               check("sweep3", 32'({bus3.cout, bus3.sum}), 32'(ia + ib + ic));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: computes a + b + cin for WIDTH-bit operands, one bit per clock, using a single full-adder cell and a carry flip-flop.
- Performs the additive counterpart of the lab's full-subtractor cell. It is the area-minimal arithmetic datapath element for the sequential labs.
- Uses a start/busy/done handshake toward a controlling testbench or FSM.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal values: 2 and above).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum and cout become valid
- sum  output  WIDTH  result bits; held stable until the next accepted start
- cout  output  1  final carry-out; held like sum

Behaviour:
- Reset (rst_n=0, asynchronous): state goes to IDLE. busy=0, done=0, sum=0, cout=0. Shift registers, carry flip-flop and bit counter are cleared. Reset mid-operation aborts the operation with no done pulse. Operation resumes on the first clock edge after rst_n rises.
- States:
  - IDLE: start=1 at edge E0 loads A_sh=a, B_sh=b, carry=cin, count=0, then goes to RUN. busy=1 from E0.
  - RUN: at each edge, compute bit s = A_sh[0]^B_sh[0]^carry and next carry = (A_sh[0]&B_sh[0]) | (carry&(A_sh[0]^B_sh[0])). Shift A_sh and B_sh right by one. Shift s into the MSB of the sum shift register. Increment count.
  - RUN exit: at the edge where count reaches WIDTH-1 (edge E_WIDTH), the last bit is shifted in. sum/cout outputs are updated from the shift register and carry. done=1, busy=0, state goes to IDLE.
- Latency: the done pulse is high for exactly the single cycle following edge E_WIDTH, i.e. WIDTH clock edges after the start edge.
- sum/cout outputs change only at E_WIDTH. Intermediate shifting is never visible on the ports.
- start while busy=1 is ignored. Operands presented during RUN have no effect.
- start held high continuously: a new operation is accepted at the edge ending the done cycle (back-to-back). Throughput is one result per WIDTH+1 cycles.
- start asserted in the done cycle is accepted, because the state is already IDLE.
- done deasserts after one cycle regardless of start.
- Arithmetic: {cout,sum} = a + b + cin exactly, modulo 2^(WIDTH+1). cout=1 on unsigned overflow.
- Internals: the bit counter is $clog2(WIDTH) bits wide and wrap-safe. No combinational path from any input to any output.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy high for 8 cycles; done pulse exactly 8 edges after the start edge; sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start a=0x10, b=0x20; at the 3rd RUN edge drive start=1 with a=0xAA, b=0x55 -> first result 0x30 / cout 0 delivered on time; second request ignored (no extra done).
- start held high, operands 0x01+0x01 then 0x80+0x80 -> results 0x02/0 then 0x00/1; done pulses exactly 9 cycles apart.
- Assert rst_n=0 mid-operation (after 4 RUN edges), asynchronously between clock edges -> busy/done/sum/cout go to 0 immediately; no done pulse. A new start afterwards with 0x0F+0x01 -> sum=0x10.
- Exhaustive sweep at WIDTH=3: all a, b in 0..7 and cin in 0..1 -> {cout,sum} equals a+b+cin for all 128 cases.
